// File: rtl/alu_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_wb_pkg                                                      |
// | Brief    : Shared types and flag bit positions for the ALU writeback stage |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_wb_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef logic [3:0] flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_cond_check.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_cond_check                                                  |
// | Brief    : Combinational ARM condition-code evaluation against NZCV flags  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_cond_check
  import alu_wb_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = w_z;
      NE: pass = !w_z;
      CS: pass = w_c;
      CC: pass = !w_c;
      MI: pass = w_n;
      PL: pass = !w_n;
      VS: pass = w_v;
      VC: pass = !w_v;
      HI: pass = w_c && !w_z;
      LS: pass = !w_c || w_z;
      GE: pass = (w_n == w_v);
      LT: pass = (w_n != w_v);
      GT: pass = !w_z && (w_n == w_v);
      LE: pass = w_z || (w_n != w_v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_writeback_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_writeback_stage                                             |
// | Brief    : Conditional flag commit and result FIFO for the 4-bit ALU.      |
// |            Define ALU_WB_STATS_EN to add commit/squash counters.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int W     = 4,
  parameter int RDW   = 3,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_result,
  input  logic [3:0]     in_flags,
  input  logic [3:0]     in_cond,
  input  logic [1:0]     in_flag_wr,
  input  logic [RDW-1:0] in_rd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_result,
  output logic [RDW-1:0] out_rd,
  output logic [3:0]     flags_q
`ifdef ALU_WB_STATS_EN
  ,
  output logic [15:0]    stat_commit,
  output logic [15:0]    stat_squash
`endif
);

  localparam int C_ADDR_W = $clog2(DEPTH);
  localparam int C_CNT_W  = C_ADDR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

  logic [W-1:0]        r_mem_result [DEPTH];
  logic [RDW-1:0]      r_mem_rd     [DEPTH];
  logic [C_ADDR_W-1:0] r_wr_ptr;
  logic [C_ADDR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0]  r_count;
  flags_t              r_flags;

  logic w_pass, w_accept, w_push, w_pop;

  alu_cond_check u_cond_check (
    .cond  (in_cond),
    .flags (r_flags),
    .pass  (w_pass)
  );

  // in_ready depends only on registered count, never on out_ready
  assign in_ready   = (r_count != C_FULL);
  assign out_valid  = (r_count != '0);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && w_pass;
  assign w_pop      = out_valid && out_ready;
  assign out_result = r_mem_result[r_rd_ptr];
  assign out_rd     = r_mem_rd[r_rd_ptr];
  assign flags_q    = r_flags;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= in_result;
      r_mem_rd[r_wr_ptr]     <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Flags load at the same edge as the push so the next op sees them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_push) begin
      if (in_flag_wr[1]) begin
        r_flags[FLAG_N] <= in_flags[FLAG_N];
        r_flags[FLAG_Z] <= in_flags[FLAG_Z];
      end
      if (in_flag_wr[0]) begin
        r_flags[FLAG_C] <= in_flags[FLAG_C];
        r_flags[FLAG_V] <= in_flags[FLAG_V];
      end
    end
  end

`ifdef ALU_WB_STATS_EN
  logic [15:0] r_stat_commit;
  logic [15:0] r_stat_squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_commit <= '0;
      r_stat_squash <= '0;
    end else if (w_accept) begin
      if (w_pass && (r_stat_commit != 16'hFFFF))
        r_stat_commit <= r_stat_commit + 16'd1;
      if (!w_pass && (r_stat_squash != 16'hFFFF))
        r_stat_squash <= r_stat_squash + 16'd1;
    end
  end

  assign stat_commit = r_stat_commit;
  assign stat_squash = r_stat_squash;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_writeback_stage                                          |
// | Brief    : Scoreboard bench for alu_writeback_stage (ALU_WB_STATS_EN aware)|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_writeback_stage;

  localparam int W     = 4;
  localparam int RDW   = 3;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_result;
  logic [3:0]     in_flags;
  logic [3:0]     in_cond;
  logic [1:0]     in_flag_wr;
  logic [RDW-1:0] in_rd;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic [RDW-1:0] out_rd;
  logic [3:0]     flags_q;
`ifdef ALU_WB_STATS_EN
  logic [15:0]    stat_commit;
  logic [15:0]    stat_squash;
`endif

  alu_writeback_stage #(.W(W), .RDW(RDW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_cond    (in_cond),
    .in_flag_wr (in_flag_wr),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .flags_q    (flags_q)
`ifdef ALU_WB_STATS_EN
    ,
    .stat_commit(stat_commit),
    .stat_squash(stat_squash)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   res;
    logic [RDW-1:0] rd;
  } ent_t;

  ent_t       r_sb[$];
  logic [3:0] r_mflags;
  int         r_mcommit;
  int         r_msquash;
  int         r_tests;
  int         r_fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_tests++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flags bit order: [0]=N [1]=Z [2]=C [3]=V
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[0]; z = f[1]; cf = f[2]; v = f[3];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf & !z;
      4'h9: return !cf | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Checks current outputs against the model, then advances model by one edge
  task automatic cycle();
    int   cnt;
    bit   acc, pass;
    ent_t e;
    cnt = r_sb.size();
    chk("in_ready", in_ready, cnt < DEPTH);
    chk("out_valid", out_valid, cnt > 0);
    if (cnt > 0) begin
      chk("out_result", out_result, r_sb[0].res);
      chk("out_rd", out_rd, r_sb[0].rd);
    end
    chk("flags_q", flags_q, r_mflags);
    acc  = in_valid && (cnt < DEPTH);
    pass = cond_ok(in_cond, r_mflags);
    if (cnt > 0 && out_ready) e = r_sb.pop_front();
    if (acc && pass) begin
      e.res = in_result;
      e.rd  = in_rd;
      r_sb.push_back(e);
      if (in_flag_wr[1]) begin r_mflags[0] = in_flags[0]; r_mflags[1] = in_flags[1]; end
      if (in_flag_wr[0]) begin r_mflags[2] = in_flags[2]; r_mflags[3] = in_flags[3]; end
      if (r_mcommit < 65535) r_mcommit++;
    end else if (acc) begin
      if (r_msquash < 65535) r_msquash++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic v, input logic [3:0] c, input logic [W-1:0] r,
                    input logic [3:0] f, input logic [1:0] fw,
                    input logic [RDW-1:0] rd, input logic ordy);
    in_valid = v; in_cond = c; in_result = r; in_flags = f;
    in_flag_wr = fw; in_rd = rd; out_ready = ordy;
    cycle();
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) op(1'b0, 4'hE, '0, 4'h0, 2'b00, '0, ordy);
  endtask

  initial begin
    r_tests = 0; r_fails = 0; r_mflags = 4'h0; r_mcommit = 0; r_msquash = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
    in_cond = 4'hE; in_flag_wr = '0; in_rd = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", flags_q, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // AL op into empty FIFO appears next cycle
    op(1, 4'hE, 4'h5, 4'b0000, 2'b11, 3'd1, 1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_result", out_result, 4'h5);
    idle(1, 2);

    // Z set by op A is seen by op B in the very next cycle
    op(1, 4'hE, 4'h3, 4'b0010, 2'b10, 3'd2, 1);
    op(1, 4'h0, 4'h9, 4'b0000, 2'b00, 3'd3, 1);
    op(1, 4'h1, 4'h9, 4'b0000, 2'b00, 3'd4, 1);
    idle(1, 2);
    chk("t2_squash_empty", out_valid, 0);

    // C,V-only update
    op(1, 4'hE, 4'h0, 4'b0000, 2'b11, 3'd1, 1);
    op(1, 4'hE, 4'h1, 4'b1111, 2'b01, 3'd2, 1);
    idle(1, 2);
    chk("t3_flags", flags_q, 4'b1100);

    // Fill with out_ready low, 5th held
    for (int i = 0; i < 4; i++) op(1, 4'hE, W'(i + 6), 4'h0, 2'b00, RDW'(i), 0);
    chk("t4_full", in_ready, 0);
    op(1, 4'hE, 4'hA, 4'h0, 2'b00, 3'd7, 0);
    op(1, 4'hE, 4'hA, 4'h0, 2'b00, 3'd7, 0);
    idle(1, 6);

    // Full with out_ready high: first cycle pops only, next accepts
    for (int i = 0; i < 4; i++) op(1, 4'hE, W'(i + 1), 4'h0, 2'b00, RDW'(i + 4), 0);
    op(1, 4'hE, 4'hB, 4'h0, 2'b00, 3'd5, 1);
    op(1, 4'hE, 4'hB, 4'h0, 2'b00, 3'd5, 1);
    idle(1, 6);

    // Steady push+pop at count 2, pointers wrap
    op(1, 4'hE, 4'hC, 4'h0, 2'b00, 3'd0, 0);
    op(1, 4'hE, 4'hD, 4'h0, 2'b00, 3'd1, 0);
    for (int i = 0; i < 8; i++) op(1, 4'hE, W'(i * 3), 4'h0, 2'b00, RDW'(i), 1);
    chk("t5_steady_ready", in_ready, 1);
    idle(1, 4);

    // Async reset with 3 entries buffered
    op(1, 4'hE, 4'h1, 4'b1010, 2'b11, 3'd1, 0);
    op(1, 4'hE, 4'h2, 4'b0000, 2'b00, 3'd2, 0);
    op(1, 4'hE, 4'h3, 4'b0000, 2'b00, 3'd3, 0);
    chk("t6_pre_flags", flags_q, 4'b1010);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_flags", flags_q, 4'h0);
    chk("t6_rst_in_ready", in_ready, 1);
    r_sb.delete();
    r_mflags = 4'h0; r_mcommit = 0; r_msquash = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) op(1, 4'hE, W'(i), 4'h0, 2'b00, RDW'(i), 1);
    op(1, 4'hF, 4'h7, 4'h0, 2'b11, 3'd6, 1);
    op(1, 4'hF, 4'h7, 4'h0, 2'b11, 3'd6, 1);
    idle(1, 3);
`ifdef ALU_WB_STATS_EN
    chk("stat_commit", stat_commit, 16'd3);
    chk("stat_squash", stat_squash, 16'd2);
`endif

    // Random mix of conditions, flag writes and backpressure
    for (int i = 0; i < 80; i++)
      op(1'($urandom_range(0, 1)), 4'($urandom), W'($urandom), 4'($urandom),
         2'($urandom), RDW'($urandom), 1'($urandom_range(0, 3) != 0));
    idle(1, 6);
`ifdef ALU_WB_STATS_EN
    chk("rand_stat_commit", stat_commit, 16'(r_mcommit));
    chk("rand_stat_squash", stat_squash, 16'(r_msquash));
`endif

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
